// File: rtl/onehot_alloc_pkg.sv
// +---------------------------------------------------------------------------+
// | onehot_alloc_pkg : shared defaults and helpers for the slot allocator     |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package onehot_alloc_pkg;

  localparam int DEF_IDX_W = 3;
  localparam int MAX_IDX_W = 6;
  localparam int MAX_SLOTS = 1 << MAX_IDX_W;

  // Population count over the widest supported slot vector; callers zero-extend.
  function automatic logic [MAX_IDX_W:0] popcount(input logic [MAX_SLOTS-1:0] v);
    logic [MAX_IDX_W:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      acc = acc + {{MAX_IDX_W{1'b0}}, v[i]};
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_n.sv
// +---------------------------------------------------------------------------+
// | decoder_n : generic IN_W -> 2**IN_W binary-to-one-hot decoder             |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module decoder_n #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      in,
  output logic [(1<<IN_W)-1:0] out
);

  localparam int OUT_N = 1 << IN_W;

  generate
    for (genvar i = 0; i < OUT_N; i++) begin : g_out
      assign out[i] = (in == IN_W'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/onehot_alloc.sv
// +---------------------------------------------------------------------------+
// | onehot_alloc : round-robin / lowest-first free-slot allocator             |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module onehot_alloc
  import onehot_alloc_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter bit RR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output logic [IDX_W-1:0]    alloc_idx,
  output logic [(1<<IDX_W)-1:0] alloc_onehot,
  input  logic                free_valid,
  input  logic [IDX_W-1:0]    free_idx,
  output logic [(1<<IDX_W)-1:0] busy_vec,
  output logic                full,
  output logic                empty,
  output logic [IDX_W:0]      count,
  output logic                free_err
);

  localparam int N = 1 << IDX_W;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] search_base;
  logic [N-1:0]     free_vec;
  logic [N-1:0]     rot_free;
  logic [IDX_W-1:0] offset;
  logic [N-1:0]     alloc_dec;
  logic [N-1:0]     free_dec;
  logic             free_hit;
  logic             free_miss;
  logic [N-1:0]     clr_mask;
  logic [IDX_W:0]   count_nxt;

  assign full  = &busy_vec;
  assign empty = ~|busy_vec;

  // Rotate the free map so the search always starts at bit 0, then undo the
  // rotation by adding the base back (mod N falls out of the IDX_W width).
  assign search_base = RR_EN ? ptr : '0;
  assign free_vec    = ~busy_vec;
  assign rot_free    = N'({free_vec, free_vec} >> search_base);

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_free[i]) offset = IDX_W'(i);
    end
  end

  assign alloc_idx    = search_base + offset;
  assign alloc_gnt    = alloc_req & ~full & ~flush;
  assign alloc_onehot = alloc_dec & {N{alloc_gnt}};

  decoder_n #(.IN_W(IDX_W)) u_alloc_dec (
    .in  (alloc_idx),
    .out (alloc_dec)
  );

  decoder_n #(.IN_W(IDX_W)) u_free_dec (
    .in  (free_idx),
    .out (free_dec)
  );

  assign free_hit  = free_valid & busy_vec[free_idx];
  assign free_miss = free_valid & ~busy_vec[free_idx];
  assign clr_mask  = free_dec & {N{free_hit}};

  // The granted slot is free and the freed slot is busy, so they never collide.
  assign count_nxt = count + {{IDX_W{1'b0}}, alloc_gnt} - {{IDX_W{1'b0}}, free_hit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_vec <= '0;
      ptr      <= '0;
      count    <= '0;
      free_err <= 1'b0;
    end else if (flush) begin
      busy_vec <= '0;
      ptr      <= '0;
      count    <= '0;
      free_err <= 1'b0;
    end else begin
      busy_vec <= (busy_vec & ~clr_mask) | alloc_onehot;
      count    <= count_nxt;
      free_err <= free_miss;
      if (alloc_gnt) ptr <= alloc_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (popcount(MAX_SLOTS'(busy_vec)) == (MAX_IDX_W + 1)'(count));
      assert (!alloc_gnt || (alloc_onehot == (N'(1) << alloc_idx)));
      assert (alloc_gnt || (alloc_onehot == '0));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_onehot_alloc.sv
// Directed self-checking bench: RR_EN=1 instance for most steps, RR_EN=0 instance for lowest-first.
`default_nettype none

module tb_onehot_alloc;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       alloc_req;
  logic       free_valid;
  logic [2:0] free_idx;

  logic       gnt_a, full_a, empty_a, ferr_a;
  logic [2:0] idx_a;
  logic [7:0] oh_a, busy_a;
  logic [3:0] cnt_a;

  logic       gnt_b, full_b, empty_b, ferr_b;
  logic [2:0] idx_b;
  logic [7:0] oh_b, busy_b;
  logic [3:0] cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  onehot_alloc #(.IDX_W(3), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .resetn(resetn), .flush(flush), .alloc_req(alloc_req),
    .alloc_gnt(gnt_a), .alloc_idx(idx_a), .alloc_onehot(oh_a),
    .free_valid(free_valid), .free_idx(free_idx), .busy_vec(busy_a),
    .full(full_a), .empty(empty_a), .count(cnt_a), .free_err(ferr_a)
  );

  onehot_alloc #(.IDX_W(3), .RR_EN(1'b0)) dut_fx (
    .clk(clk), .resetn(resetn), .flush(flush), .alloc_req(alloc_req),
    .alloc_gnt(gnt_b), .alloc_idx(idx_b), .alloc_onehot(oh_b),
    .free_valid(free_valid), .free_idx(free_idx), .busy_vec(busy_b),
    .full(full_b), .empty(empty_b), .count(cnt_b), .free_err(ferr_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to the next negedge and apply one cycle of inputs.
  task automatic drive(input logic req, input logic fv, input logic [2:0] fi, input logic fl);
    @(negedge clk);
    alloc_req  = req;
    free_valid = fv;
    free_idx   = fi;
    flush      = fl;
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; alloc_req = 1'b0; free_valid = 1'b0; free_idx = '0;
    #2;
    check("rst_busy",  16'(busy_a),  16'h00);
    check("rst_count", 16'(cnt_a),   16'd0);
    check("rst_empty", 16'(empty_a), 16'd1);
    check("rst_full",  16'(full_a),  16'd0);
    check("rst_ferr",  16'(ferr_a),  16'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Test 1: fill all eight slots in order, then the ninth request stalls.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      check($sformatf("fill_gnt%0d", k), 16'(gnt_a), 16'd1);
      check($sformatf("fill_idx%0d", k), 16'(idx_a), 16'(k));
      check($sformatf("fill_oh%0d",  k), 16'(oh_a),  16'(8'd1 << k));
    end

    // Test 2: full, free slot 5 while requesting: no grant this cycle.
    drive(1'b1, 1'b1, 3'd5, 1'b0);
    check("full_flag",  16'(full_a), 16'd1);
    check("full_count", 16'(cnt_a),  16'd8);
    check("full_gnt",   16'(gnt_a),  16'd0);
    check("full_oh",    16'(oh_a),   16'h00);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("refill_busy", 16'(busy_a), 16'hDF);
    check("refill_cnt",  16'(cnt_a),  16'd7);
    check("refill_gnt",  16'(gnt_a),  16'd1);
    check("refill_idx",  16'(idx_a),  16'd5);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("refill_full", 16'(full_a), 16'd1);

    // Test 3: build busy=0000_0110 with ptr=7, then check the wrap.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 3'd4, 1'b0);
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    drive(1'b0, 1'b1, 3'd6, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("wrap_busy", 16'(busy_a), 16'h06);
    check("wrap_idx7", 16'(idx_a),  16'd7);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("wrap_idx0", 16'(idx_a),  16'd0);
    check("wrap_oh0",  16'(oh_a),   16'h01);

    // Test 4: double free of slot 3 is flagged for one cycle only.
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    check("dfree_pre_busy", 16'(busy_a), 16'h87);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("dfree_busy", 16'(busy_a), 16'h87);
    check("dfree_err",  16'(ferr_a), 16'd1);
    check("dfree_cnt",  16'(cnt_a),  16'd4);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("dfree_err_clr", 16'(ferr_a), 16'd0);

    // Test 5: reach count 5 (ptr=1 -> slot 3), then flush with req and free.
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("pre_flush_idx", 16'(idx_a), 16'd3);
    drive(1'b1, 1'b1, 3'd0, 1'b1);
    check("flush_cnt5", 16'(cnt_a), 16'd5);
    check("flush_gnt",  16'(gnt_a), 16'd0);
    check("flush_oh",   16'(oh_a),  16'h00);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("flush_busy",  16'(busy_a),  16'h00);
    check("flush_cnt",   16'(cnt_a),   16'd0);
    check("flush_empty", 16'(empty_a), 16'd1);
    check("flush_ferr",  16'(ferr_a),  16'd0);

    // Test 6: lowest-first instance with busy=0000_0101, then reset mid-burst.
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 3'd1, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("fx_busy", 16'(busy_b), 16'h05);
    check("fx_gnt",  16'(gnt_b),  16'd1);
    check("fx_idx",  16'(idx_b),  16'd1);
    check("fx_oh",   16'(oh_b),   16'h02);
    check("rr_idx",  16'(idx_a),  16'd3);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("fx_next_idx", 16'(idx_b), 16'd3);
    check("fx_cnt",      16'(cnt_b), 16'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_busy_fx", 16'(busy_b), 16'h00);
    check("midrst_cnt_fx",  16'(cnt_b),  16'd0);
    check("midrst_busy_rr", 16'(busy_a), 16'h00);
    check("midrst_empty",   16'(empty_b), 16'd1);
    alloc_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
